// File: rtl/invader_fleet.sv
// ---------------------------------------------------------------------------
// invader_fleet
//
// Owns the row of six invaders: alive flags, formation position, the
// march / drop / reverse pattern and laser-versus-invader hit detection.
//
// Ports
//   clk               system clock
//   rst               synchronous active-low reset
//   frame             one-cycle pulse per video frame
//   laser_active      player laser in flight
//   laser_x/laser_y   laser tip position
//   fleet_x/fleet_y   top-left corner of invader 0
//   alive             per-invader alive flags, bit i = invader i (left to right)
//   invader_collision one-hot, one-cycle hit pulse
//   wave_cleared      high while every invader is dead and waiting to respawn
//   invaded           high once the fleet has reached the invasion line
// ---------------------------------------------------------------------------
module invader_fleet #(
   parameter int INV_W          = 32,
   parameter int INV_H          = 16,
   parameter int PITCH          = 64,
   parameter int STEP_X         = 4,
   parameter int DROP_Y         = 16,
   parameter int MOVE_FRAMES    = 30,
   parameter int LEFT_BOUND     = 16,
   parameter int RIGHT_BOUND    = 624,
   parameter int START_X        = 112,
   parameter int START_Y        = 48,
   parameter int INVADE_Y       = 400,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame,
   input  logic       laser_active,
   input  logic [9:0] laser_x,
   input  logic [9:0] laser_y,
   output logic [9:0] fleet_x,
   output logic [9:0] fleet_y,
   output logic [5:0] alive,
   output logic [5:0] invader_collision,
   output logic       wave_cleared,
   output logic       invaded
);

   // One counter serves both the march cadence and the respawn delay.
   localparam int CNT_MAX = (MOVE_FRAMES > RESPAWN_FRAMES) ? MOVE_FRAMES : RESPAWN_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      MARCH,
      CLEARED,
      INVADED
   } fleetState_t;

   fleetState_t      r_state;
   logic [9:0]       r_fleetX;
   logic [9:0]       r_fleetY;
   logic [5:0]       r_alive;
   logic [5:0]       r_collision;
   logic             r_dirRight;
   logic             r_waveCleared;
   logic             r_invaded;
   logic [CNT_W-1:0] r_frameCnt;

   logic [10:0]      w_xExt;
   logic [10:0]      w_yExt;
   logic [10:0]      w_laserXExt;
   logic [10:0]      w_laserYExt;
   logic             w_rowHit;
   logic [5:0]       w_hitOneHot;
   logic [5:0]       w_aliveAfterHit;
   logic             w_moveDue;
   logic             w_respawnDue;
   logic             w_atRight;
   logic             w_atLeft;
   logic             w_invadeNow;

   // Hit detection and boundary tests. Everything is widened to 11 bits so
   // the right-edge sum cannot wrap. The laser must be inside the fleet row
   // vertically; horizontally each live invader is tested and only the
   // lowest-indexed qualifying one is reported.
   always_comb begin
      w_xExt      = {1'b0, r_fleetX};
      w_yExt      = {1'b0, r_fleetY};
      w_laserXExt = {1'b0, laser_x};
      w_laserYExt = {1'b0, laser_y};
      w_rowHit    = laser_active &&
                    (w_laserYExt >= w_yExt) &&
                    (w_laserYExt <  w_yExt + 11'(INV_H));
      w_hitOneHot = '0;
      for (int i = 0; i < 6; i++) begin
         if ((w_hitOneHot == 6'd0) && w_rowHit && r_alive[i] &&
             (w_laserXExt >= w_xExt + 11'(i * PITCH)) &&
             (w_laserXExt <  w_xExt + 11'(i * PITCH + INV_W))) begin
            w_hitOneHot[i] = 1'b1;
         end
      end
      w_aliveAfterHit = r_alive & ~w_hitOneHot;
      w_moveDue       = frame && (r_frameCnt == CNT_W'(MOVE_FRAMES - 1));
      w_respawnDue    = frame && (r_frameCnt == CNT_W'(RESPAWN_FRAMES - 1));
      w_atRight       = (w_xExt + 11'(5 * PITCH + INV_W + STEP_X)) > 11'(RIGHT_BOUND);
      w_atLeft        = w_xExt < 11'(LEFT_BOUND + STEP_X);
      w_invadeNow     = (w_yExt + 11'(INV_H)) >= 11'(INVADE_Y);
   end

   // Fleet state machine. The invasion test runs every cycle in MARCH, but
   // since y only grows on a drop it first fires the cycle after the drop
   // lands, and it beats any kill arriving in that same cycle. A kill that
   // empties the row beats a coinciding move, so the wave clears in place.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= MARCH;
         r_fleetX      <= 10'(START_X);
         r_fleetY      <= 10'(START_Y);
         r_alive       <= 6'b111111;
         r_collision   <= '0;
         r_dirRight    <= 1'b1;
         r_waveCleared <= 1'b0;
         r_invaded     <= 1'b0;
         r_frameCnt    <= '0;
      end else begin
         r_collision <= '0;
         case (r_state)
            MARCH: begin
               if (w_invadeNow) begin
                  r_state   <= INVADED;
                  r_invaded <= 1'b1;
               end else begin
                  r_collision <= w_hitOneHot;
                  r_alive     <= w_aliveAfterHit;
                  if (w_aliveAfterHit == 6'd0) begin
                     r_state       <= CLEARED;
                     r_waveCleared <= 1'b1;
                     r_frameCnt    <= '0;
                  end else if (frame) begin
                     if (w_moveDue) begin
                        r_frameCnt <= '0;
                        if (r_dirRight ? w_atRight : w_atLeft) begin
                           r_fleetY   <= r_fleetY + 10'(DROP_Y);
                           r_dirRight <= ~r_dirRight;
                        end else if (r_dirRight) begin
                           r_fleetX <= r_fleetX + 10'(STEP_X);
                        end else begin
                           r_fleetX <= r_fleetX - 10'(STEP_X);
                        end
                     end else begin
                        r_frameCnt <= r_frameCnt + CNT_W'(1);
                     end
                  end
               end
            end
            CLEARED: begin
               if (frame) begin
                  if (w_respawnDue) begin
                     r_state       <= MARCH;
                     r_waveCleared <= 1'b0;
                     r_fleetX      <= 10'(START_X);
                     r_fleetY      <= 10'(START_Y);
                     r_alive       <= 6'b111111;
                     r_dirRight    <= 1'b1;
                     r_frameCnt    <= '0;
                  end else begin
                     r_frameCnt <= r_frameCnt + CNT_W'(1);
                  end
               end
            end
            INVADED: begin
               r_state <= INVADED;
            end
            default: begin
               r_state <= MARCH;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   assign fleet_x           = r_fleetX;
   assign fleet_y           = r_fleetY;
   assign alive             = r_alive;
   assign invader_collision = r_collision;
   assign wave_cleared      = r_waveCleared;
   assign invaded           = r_invaded;

endmodule

// File: tb/tb_invader_fleet.sv
// ---------------------------------------------------------------------------
// tb_invader_fleet
//
// Drives invader_fleet with directed scenarios plus a randomized run and
// compares every output against a behavioural model of the fleet rules.
// ---------------------------------------------------------------------------
module tb_invader_fleet;

   localparam int INV_W          = 32;
   localparam int INV_H          = 16;
   localparam int PITCH          = 64;
   localparam int STEP_X         = 4;
   localparam int DROP_Y         = 16;
   localparam int MOVE_FRAMES    = 30;
   localparam int LEFT_BOUND     = 16;
   localparam int RIGHT_BOUND    = 624;
   localparam int START_X        = 112;
   localparam int START_Y        = 48;
   localparam int INVADE_Y       = 400;
   localparam int RESPAWN_FRAMES = 60;

   localparam int MODE_MARCH   = 0;
   localparam int MODE_CLEARED = 1;
   localparam int MODE_INVADED = 2;

   logic       clk         = 1'b0;
   logic       rst         = 1'b0;
   logic       frame       = 1'b0;
   logic       laserActive = 1'b0;
   logic [9:0] laserX      = '0;
   logic [9:0] laserY      = '0;
   logic [9:0] fleetX;
   logic [9:0] fleetY;
   logic [5:0] alive;
   logic [5:0] collision;
   logic       waveCleared;
   logic       invaded;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the fleet.
   int         mX      = START_X;
   int         mY      = START_Y;
   int         mFrames = 0;
   int         mMode   = MODE_MARCH;
   bit         mRight  = 1'b1;
   logic [5:0] mAlive  = 6'h3F;
   logic [5:0] mColl   = 6'h00;

   invader_fleet dut (
      .clk               (clk),
      .rst               (rst),
      .frame             (frame),
      .laser_active      (laserActive),
      .laser_x           (laserX),
      .laser_y           (laserY),
      .fleet_x           (fleetX),
      .fleet_y           (fleetY),
      .alive             (alive),
      .invader_collision (collision),
      .wave_cleared      (waveCleared),
      .invaded           (invaded)
   );

   always #5 clk = ~clk;

   // Advances the model by one clock edge using the inputs seen at that edge.
   // Which invader is under the laser comes from dividing the offset by the
   // pitch rather than scanning invaders one by one.
   task automatic modelStep();
      int off;
      int k;
      if (!rst) begin
         mX = START_X; mY = START_Y; mAlive = 6'h3F; mColl = 6'h00;
         mRight = 1'b1; mFrames = 0; mMode = MODE_MARCH;
         return;
      end
      mColl = 6'h00;
      if (mMode == MODE_MARCH) begin
         if (mY + INV_H >= INVADE_Y) begin
            mMode = MODE_INVADED;
            return;
         end
         if (laserActive && int'(laserX) >= mX && int'(laserY) >= mY && int'(laserY) < mY + INV_H) begin
            off = int'(laserX) - mX;
            k   = off / PITCH;
            if (k < 6 && (off % PITCH) < INV_W && mAlive[k]) begin
               mColl[k]  = 1'b1;
               mAlive[k] = 1'b0;
            end
         end
         if (mAlive == 6'h00) begin
            mMode   = MODE_CLEARED;
            mFrames = 0;
         end else if (frame) begin
            mFrames++;
            if (mFrames == MOVE_FRAMES) begin
               mFrames = 0;
               if (mRight && mX + 5 * PITCH + INV_W + STEP_X > RIGHT_BOUND) begin
                  mY += DROP_Y; mRight = 1'b0;
               end else if (!mRight && mX < LEFT_BOUND + STEP_X) begin
                  mY += DROP_Y; mRight = 1'b1;
               end else begin
                  mX += mRight ? STEP_X : -STEP_X;
               end
            end
         end
      end else if (mMode == MODE_CLEARED) begin
         if (frame) begin
            mFrames++;
            if (mFrames == RESPAWN_FRAMES) begin
               mX = START_X; mY = START_Y; mAlive = 6'h3F;
               mRight = 1'b1; mFrames = 0; mMode = MODE_MARCH;
            end
         end
      end
   endtask

   // One clock: DUT and model both take the edge, outputs are sampled 1 ns later.
   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b0; frame = 1'b0; laserActive = 1'b0;
      for (int i = 0; i < cycles; i++) applyStimulus();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; laserActive = 1'b1; laserX = 10'd240; laserY = 10'd50;
      for (int i = 0; i < 3; i++) begin
         frame = 1'b1;
         applyStimulus();
      end
      frame = 1'b0; laserActive = 1'b0; rst = 1'b1;
      checks++; if (fleetX !== 10'd112) begin errors++; $display("[TB] FAIL reset fleet_x: got %0d expected 112", fleetX); end
      checks++; if (fleetY !== 10'd48) begin errors++; $display("[TB] FAIL reset fleet_y: got %0d expected 48", fleetY); end
      checks++; if (alive !== 6'h3F) begin errors++; $display("[TB] FAIL reset alive: got %h expected 3f", alive); end
      checks++; if (collision !== 6'h00) begin errors++; $display("[TB] FAIL reset collision: got %h expected 00", collision); end
      checks++; if (waveCleared !== 1'b0 || invaded !== 1'b0) begin
         errors++; $display("[TB] FAIL reset flags: got wave=%b inv=%b expected 0 0", waveCleared, invaded);
      end
   endtask

   task automatic test_march();
      doReset(1);
      for (int i = 0; i < MOVE_FRAMES; i++) begin
         frame = 1'b1; applyStimulus();
         frame = 1'b0; applyStimulus();
      end
      checks++; if (fleetX !== 10'd116) begin errors++; $display("[TB] FAIL march first step: got %0d expected 116", fleetX); end
      frame = 1'b1;
      for (int i = 0; i < 39 * MOVE_FRAMES; i++) applyStimulus();
      checks++; if (fleetX !== 10'd272 || fleetY !== 10'd48) begin
         errors++; $display("[TB] FAIL march 40 moves: got x=%0d y=%0d expected 272 48", fleetX, fleetY);
      end
      for (int i = 0; i < MOVE_FRAMES; i++) applyStimulus();
      checks++; if (fleetX !== 10'd272 || fleetY !== 10'd64) begin
         errors++; $display("[TB] FAIL march drop: got x=%0d y=%0d expected 272 64", fleetX, fleetY);
      end
      for (int i = 0; i < MOVE_FRAMES; i++) applyStimulus();
      frame = 1'b0;
      checks++; if (fleetX !== 10'd268 || fleetY !== 10'd64) begin
         errors++; $display("[TB] FAIL march reverse: got x=%0d y=%0d expected 268 64", fleetX, fleetY);
      end
      checks++; if (fleetX !== 10'(mX) || fleetY !== 10'(mY)) begin
         errors++; $display("[TB] FAIL march model: got x=%0d y=%0d expected %0d %0d", fleetX, fleetY, mX, mY);
      end
   endtask

   task automatic test_hit();
      doReset(1);
      laserActive = 1'b1; laserX = 10'd240; laserY = 10'd50;
      applyStimulus();
      checks++; if (collision !== 6'b000100) begin errors++; $display("[TB] FAIL hit pulse: got %b expected 000100", collision); end
      checks++; if (alive !== 6'b111011) begin errors++; $display("[TB] FAIL hit alive: got %b expected 111011", alive); end
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         checks++; if (collision !== 6'b000000) begin errors++; $display("[TB] FAIL hit linger cycle %0d: got %b expected 000000", i, collision); end
      end
      laserX = 10'd208;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checks++; if (collision !== 6'b000000 || alive !== 6'b111011) begin
            errors++; $display("[TB] FAIL hit gap: got coll=%b alive=%b expected 000000 111011", collision, alive);
         end
      end
      laserActive = 1'b0;
   endtask

   task automatic test_simultaneous();
      doReset(1);
      frame = 1'b1;
      for (int i = 0; i < MOVE_FRAMES - 1; i++) applyStimulus();
      laserActive = 1'b1; laserX = 10'd112; laserY = 10'd48;
      applyStimulus();
      frame = 1'b0; laserActive = 1'b0;
      checks++; if (collision !== 6'b000001 || alive !== 6'b111110) begin
         errors++; $display("[TB] FAIL simultaneous hit: got coll=%b alive=%b expected 000001 111110", collision, alive);
      end
      checks++; if (fleetX !== 10'd116) begin errors++; $display("[TB] FAIL simultaneous move: got %0d expected 116", fleetX); end
   endtask

   task automatic test_clear_respawn();
      doReset(1);
      laserY = 10'd63;
      for (int i = 0; i < 5; i++) begin
         laserActive = 1'b1; laserX = 10'(START_X + i * PITCH + INV_W - 1);
         applyStimulus();
         laserActive = 1'b0;
         applyStimulus();
      end
      checks++; if (alive !== 6'b100000) begin errors++; $display("[TB] FAIL clear five kills: got %b expected 100000", alive); end
      frame = 1'b1;
      for (int i = 0; i < MOVE_FRAMES - 1; i++) applyStimulus();
      laserActive = 1'b1; laserX = 10'(START_X + 5 * PITCH + INV_W - 1);
      applyStimulus();
      frame = 1'b0;
      checks++; if (waveCleared !== 1'b1 || collision !== 6'b100000 || alive !== 6'b000000) begin
         errors++; $display("[TB] FAIL clear last kill: got wave=%b coll=%b alive=%b expected 1 100000 000000", waveCleared, collision, alive);
      end
      checks++; if (fleetX !== 10'd112) begin errors++; $display("[TB] FAIL clear no move: got %0d expected 112", fleetX); end
      laserX = 10'd112; laserY = 10'd50;
      for (int i = 0; i < RESPAWN_FRAMES - 1; i++) begin
         frame = 1'b1; applyStimulus();
         frame = 1'b0; applyStimulus();
         checks++; if (collision !== 6'b000000) begin errors++; $display("[TB] FAIL cleared laser ignored: got %b expected 000000", collision); end
      end
      checks++; if (waveCleared !== 1'b1) begin errors++; $display("[TB] FAIL cleared hold: got %b expected 1", waveCleared); end
      laserActive = 1'b0; frame = 1'b1;
      applyStimulus();
      frame = 1'b0;
      checks++; if (alive !== 6'h3F || fleetX !== 10'd112 || fleetY !== 10'd48 || waveCleared !== 1'b0) begin
         errors++; $display("[TB] FAIL respawn: got alive=%h x=%0d y=%0d wave=%b expected 3f 112 48 0", alive, fleetX, fleetY, waveCleared);
      end
   endtask

   task automatic test_random();
      doReset(1);
      for (int n = 0; n < 3000; n++) begin
         frame       = 1'($urandom_range(0, 1));
         laserActive = 1'($urandom_range(0, 1));
         laserX      = 10'($urandom_range(0, 639));
         laserY      = 10'(mY - 8 + int'($urandom_range(0, 31)));
         applyStimulus();
         checks++; if (fleetX !== 10'(mX)) begin errors++; $display("[TB] FAIL rand fleet_x cycle %0d: got %0d expected %0d", n, fleetX, mX); end
         checks++; if (fleetY !== 10'(mY)) begin errors++; $display("[TB] FAIL rand fleet_y cycle %0d: got %0d expected %0d", n, fleetY, mY); end
         checks++; if (alive !== mAlive) begin errors++; $display("[TB] FAIL rand alive cycle %0d: got %b expected %b", n, alive, mAlive); end
         checks++; if (collision !== mColl) begin errors++; $display("[TB] FAIL rand collision cycle %0d: got %b expected %b", n, collision, mColl); end
         checks++; if (waveCleared !== (mMode == MODE_CLEARED)) begin
            errors++; $display("[TB] FAIL rand wave_cleared cycle %0d: got %b expected %b", n, waveCleared, mMode == MODE_CLEARED);
         end
         checks++; if (invaded !== (mMode == MODE_INVADED)) begin
            errors++; $display("[TB] FAIL rand invaded cycle %0d: got %b expected %b", n, invaded, mMode == MODE_INVADED);
         end
      end
      frame = 1'b0; laserActive = 1'b0;
   endtask

   task automatic test_invasion();
      int budget;
      doReset(1);
      frame  = 1'b1;
      budget = 45000;
      while (invaded !== 1'b1 && budget > 0) begin
         applyStimulus();
         budget--;
      end
      checks++; if (invaded !== 1'b1) begin errors++; $display("[TB] FAIL invasion timeout: got invaded=%b expected 1", invaded); end
      checks++; if (fleetY !== 10'd384 || fleetX !== 10'(mX) || mMode != MODE_INVADED) begin
         errors++; $display("[TB] FAIL invasion position: got x=%0d y=%0d expected %0d 384", fleetX, fleetY, mX);
      end
      for (int i = 0; i < 100; i++) applyStimulus();
      frame = 1'b0;
      checks++; if (invaded !== 1'b1 || fleetY !== 10'd384 || fleetX !== 10'(mX) || alive !== 6'h3F) begin
         errors++; $display("[TB] FAIL invasion frozen: got inv=%b x=%0d y=%0d alive=%h expected 1 %0d 384 3f", invaded, fleetX, fleetY, alive, mX);
      end
      rst = 1'b0;
      applyStimulus();
      rst = 1'b1;
      checks++; if (fleetX !== 10'd112 || fleetY !== 10'd48 || alive !== 6'h3F || invaded !== 1'b0 || waveCleared !== 1'b0 || collision !== 6'h00) begin
         errors++; $display("[TB] FAIL invasion reset: got x=%0d y=%0d alive=%h inv=%b wave=%b coll=%h expected 112 48 3f 0 0 00",
                            fleetX, fleetY, alive, invaded, waveCleared, collision);
      end
   endtask

   initial begin
      test_reset();
      test_march();
      test_hit();
      test_simultaneous();
      test_clear_respawn();
      test_random();
      test_invasion();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
